// File: rtl/psum_stream_tx.sv
// psum_stream_tx
//   Reads per-kernel-position partial-sum rows out of the psum SRAM and streams
//   them over a valid/ready interface into the accumulate+ReLU stage. For every
//   output pixel o (outer loop) it emits num_kij rows (inner loop over kij).
//   The final kij row of each pixel is tagged with psum_last.
//
//   Read data arriving from the SRAM is presented directly on the output when
//   the skid buffer is empty, so the first row is valid two cycles after start
//   and a full row per cycle is sustained while psum_ready stays high. The
//   in-flight read counts against the 2-entry buffer, so a row is never dropped.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start                one-cycle pulse, begins a pass when idle
//   base_addr            SRAM address of (kij=0, o=0), sampled on start
//   num_kij, num_out     pass geometry, sampled on start
//   busy, done           pass in progress / one-cycle completion pulse
//   mem_rd, mem_addr     SRAM read strobe and address (data 1 cycle later)
//   mem_rdata            SRAM read data
//   psum_valid/ready     output handshake
//   psum_data, psum_last output row and end-of-pixel tag
module psum_stream_tx #(
  parameter int bw  = 4,
  parameter int col = 8,
  parameter int AW  = 11,
  parameter int KW  = 4,
  parameter int OW  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [KW-1:0]     num_kij,
  input  logic [OW-1:0]     num_out,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [bw*col-1:0] mem_rdata,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic [bw*col-1:0] psum_data,
  output logic              psum_last
);

  localparam int DW = bw * col;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] num_kij_q, num_kij_d;
  logic [OW-1:0] num_out_q, num_out_d;
  logic [KW-1:0] kij_q, kij_d;
  logic [OW-1:0] o_q, o_d;
  // Address of the next read, and base+o for the current pixel. Both are
  // advanced by addition only: +num_out along kij, +1 when moving to next o.
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic          done_q, done_d;

  // Read issued last cycle; its data is on mem_rdata this cycle.
  logic          rd_pend_q, rd_pend_d;
  logic          last_pend_q, last_pend_d;

  // Skid buffer: entry 0 is the head.
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] ent0_data_q, ent0_data_d;
  logic [DW-1:0] ent1_data_q, ent1_data_d;
  logic          ent0_last_q, ent0_last_d;
  logic          ent1_last_q, ent1_last_d;

  logic          pop;
  logic [1:0]    occ;
  logic [1:0]    occ_after_pop;
  logic          last_row_issue;
  logic          final_issue;
  logic [DW-1:0] head_data;
  logic          head_last;
  logic [DW-1:0] item0_data, item1_data;
  logic          item0_last, item1_last;

  // Handshake, occupancy and read-issue decision
  always_comb begin
    occ           = cnt_q + {1'b0, rd_pend_q};
    psum_valid    = (cnt_q != 2'd0) || rd_pend_q;
    pop           = psum_valid && psum_ready;
    occ_after_pop = occ - {1'b0, pop};

    head_data = (cnt_q != 2'd0) ? ent0_data_q : mem_rdata;
    head_last = (cnt_q != 2'd0) ? ent0_last_q : last_pend_q;
    psum_data = psum_valid ? head_data : '0;
    psum_last = psum_valid ? head_last : 1'b0;

    mem_rd   = (state_q == ST_RUN) && (occ_after_pop < 2'd2);
    mem_addr = addr_q;
    busy     = (state_q != ST_IDLE);
    done     = done_q;

    last_row_issue = (kij_q == num_kij_q - KW'(1));
    final_issue    = last_row_issue && (o_q == num_out_q - OW'(1));
  end

  // Pass sequencing
  always_comb begin
    state_d     = state_q;
    num_kij_d   = num_kij_q;
    num_out_d   = num_out_q;
    kij_d       = kij_q;
    o_d         = o_q;
    addr_d      = addr_q;
    pix_addr_d  = pix_addr_q;
    done_d      = 1'b0;
    rd_pend_d   = mem_rd;
    last_pend_d = mem_rd ? last_row_issue : 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((num_kij == '0) || (num_out == '0)) begin
            // Empty pass: complete immediately without touching the SRAM.
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            num_kij_d  = num_kij;
            num_out_d  = num_out;
            kij_d      = '0;
            o_d        = '0;
            addr_d     = base_addr;
            pix_addr_d = base_addr;
          end
        end
      end
      ST_RUN: begin
        if (mem_rd) begin
          if (last_row_issue) begin
            kij_d = '0;
            if (final_issue) begin
              state_d = ST_DRAIN;
            end else begin
              o_d        = o_q + OW'(1);
              pix_addr_d = pix_addr_q + AW'(1);
              addr_d     = pix_addr_q + AW'(1);
            end
          end else begin
            kij_d  = kij_q + KW'(1);
            addr_d = addr_q + AW'(num_out_q);
          end
        end
      end
      ST_DRAIN: begin
        // No reads are issued here, so the last buffered row leaving ends the pass.
        if (pop && (occ == 2'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer update: logical order is stored entries, then arriving read
  always_comb begin
    item0_data = (cnt_q != 2'd0) ? ent0_data_q : mem_rdata;
    item0_last = (cnt_q != 2'd0) ? ent0_last_q : last_pend_q;
    item1_data = (cnt_q == 2'd2) ? ent1_data_q : mem_rdata;
    item1_last = (cnt_q == 2'd2) ? ent1_last_q : last_pend_q;

    cnt_d = occ_after_pop;
    if (pop) begin
      ent0_data_d = item1_data;
      ent0_last_d = item1_last;
    end else begin
      ent0_data_d = item0_data;
      ent0_last_d = item0_last;
    end
    ent1_data_d = item1_data;
    ent1_last_d = item1_last;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_kij_q   <= '0;
      num_out_q   <= '0;
      kij_q       <= '0;
      o_q         <= '0;
      addr_q      <= '0;
      pix_addr_q  <= '0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      cnt_q       <= '0;
      ent0_data_q <= '0;
      ent1_data_q <= '0;
      ent0_last_q <= 1'b0;
      ent1_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_kij_q   <= num_kij_d;
      num_out_q   <= num_out_d;
      kij_q       <= kij_d;
      o_q         <= o_d;
      addr_q      <= addr_d;
      pix_addr_q  <= pix_addr_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_pend_d;
      last_pend_q <= last_pend_d;
      cnt_q       <= cnt_d;
      ent0_data_q <= ent0_data_d;
      ent1_data_q <= ent1_data_d;
      ent0_last_q <= ent0_last_d;
      ent1_last_q <= ent1_last_d;
    end
  end

endmodule

// File: tb/tb_psum_stream_tx.sv
`timescale 1ns/1ps
module tb_psum_stream_tx;

  localparam int BW  = 4;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int KW  = 4;
  localparam int OW  = 7;
  localparam int DW  = BW * COL;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [KW-1:0] num_kij;
  logic [OW-1:0] num_out;
  logic          busy;
  logic          done;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          psum_valid;
  logic          psum_ready;
  logic [DW-1:0] psum_data;
  logic          psum_last;

  psum_stream_tx #(.bw(BW), .col(COL), .AW(AW), .KW(KW), .OW(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_kij    (num_kij),
    .num_out    (num_out),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_last  (psum_last)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency
  logic [DW-1:0] sram [0:MEM-1];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= sram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  typedef struct {
    int base;
    int nk;
    int no;
    int rmode;      // 0: ready high, 1: pattern 1,0,0,1, 2: random
    int restart;    // pulse a second start mid-pass
    int exp_beats;
    int exp_addr0;
  } vec_t;

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_pass(input vec_t v);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic          el[$];
    logic [AW-1:0] ga[$];
    logic [DW-1:0] gd[$];
    logic          gl[$];
    int n, budget, first_valid, last_hs, done_c, done_cnt, busy1, busy_at_done;
    n = v.nk * v.no;
    first_valid = -1; last_hs = -1; done_c = -1; done_cnt = 0; busy1 = -1; busy_at_done = 0;

    // Reference: direct address formula, row order o outer / kij inner
    for (int o = 0; o < v.no; o++) begin
      for (int k = 0; k < v.nk; k++) begin
        int a;
        a = (v.base + k * v.no + o) % MEM;
        ea.push_back(AW'(a));
        ed.push_back(sram[a]);
        el.push_back(k == v.nk - 1);
      end
    end

    budget = 4 * n + 30;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == 0) || ((v.restart != 0) && (c == 5));
      if (c == 0) begin
        base_addr = AW'(v.base);
        num_kij   = KW'(v.nk);
        num_out   = OW'(v.no);
      end else if ((v.restart != 0) && (c == 5)) begin
        base_addr = AW'(555);
        num_kij   = KW'(3);
        num_out   = OW'(3);
      end
      psum_ready = ready_for(v.rmode, c);
      #1;
      if (c == 1) busy1 = int'(busy);
      if (mem_rd) ga.push_back(mem_addr);
      if (psum_valid && first_valid < 0) first_valid = c;
      if (psum_valid && psum_ready) begin
        gd.push_back(psum_data);
        gl.push_back(psum_last);
        last_hs = c;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        if (busy) busy_at_done++;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    start = 1'b0;

    chk("done_seen_within_budget", longint'(done_c >= 0), 1);
    chk("done_pulse_count", done_cnt, 1);
    chk("busy_low_with_done", busy_at_done, 0);
    chk("busy_cycle_after_start", busy1, (n > 0) ? 1 : 0);
    chk("read_count", longint'(ga.size()), n);
    chk("beat_count", longint'(gd.size()), v.exp_beats);
    if (n > 0) begin
      chk("done_one_after_last_handshake", done_c, last_hs + 1);
      chk("first_valid_cycle", first_valid, 2);
      if (ga.size() > 0) chk("first_addr", longint'(ga[0]), v.exp_addr0);
      if (v.rmode == 0) chk("full_rate_last_handshake", last_hs, n + 1);
    end else begin
      chk("empty_done_cycle", done_c, 1);
      chk("empty_never_valid", first_valid, -1);
    end
    for (int i = 0; i < ga.size() && i < ea.size(); i++)
      chk($sformatf("addr[%0d]", i), longint'(ga[i]), longint'(ea[i]));
    for (int i = 0; i < gd.size() && i < ed.size(); i++) begin
      chk($sformatf("data[%0d]", i), longint'(gd[i]), longint'(ed[i]));
      chk($sformatf("last[%0d]", i), longint'(gl[i]), longint'(el[i]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},       longint'(busy), 0);
    chk({tag, "_done"},       longint'(done), 0);
    chk({tag, "_mem_rd"},     longint'(mem_rd), 0);
    chk({tag, "_mem_addr"},   longint'(mem_addr), 0);
    chk({tag, "_psum_valid"}, longint'(psum_valid), 0);
    chk({tag, "_psum_data"},  longint'(psum_data), 0);
    chk({tag, "_psum_last"},  longint'(psum_last), 0);
  endtask

  task automatic reset_midpass();
    int dn, vv;
    dn = 0; vv = 0;
    @(negedge clk);
    start = 1'b1; base_addr = '0; num_kij = KW'(9); num_out = OW'(4); psum_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_valid_held", longint'(psum_valid), 1);
    chk("pre_reset_buffer_full_no_read", longint'(mem_rd), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("midpass_reset");
    @(negedge clk);
    reset = 1'b0;
    psum_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (done) dn++;
      if (psum_valid || mem_rd || busy) vv++;
    end
    chk("no_done_after_reset", dn, 0);
    chk("idle_after_reset", vv, 0);
  endtask

  vec_t tbl[9];

  initial begin
    for (int i = 0; i < MEM; i++) sram[i] = DW'($urandom);
    reset = 1'b1; start = 1'b0; base_addr = '0; num_kij = '0; num_out = '0; psum_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    //           base  nk  no  rmode restart beats addr0
    tbl[0] = '{0,    9,  4,   0, 0, 36,   0};
    tbl[1] = '{0,    9,  4,   1, 0, 36,   0};
    tbl[2] = '{2046, 2,  1,   0, 0, 2,    2046};
    tbl[3] = '{2046, 2,  2,   0, 0, 4,    2046};
    tbl[4] = '{0,    0,  4,   0, 0, 0,    -1};
    tbl[5] = '{5,    3,  0,   1, 0, 0,    -1};
    tbl[6] = '{100,  9,  4,   0, 1, 36,   100};
    tbl[7] = '{7,    1,  5,   2, 0, 5,    7};
    tbl[8] = '{1000, 15, 127, 2, 0, 1905, 1000};
    for (int i = 0; i < 9; i++) run_pass(tbl[i]);

    reset_midpass();
    run_pass(tbl[0]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.base      = int'($urandom_range(0, MEM - 1));
      v.nk        = int'($urandom_range(1, 15));
      v.no        = int'($urandom_range(1, 20));
      v.rmode     = 2;
      v.restart   = int'($urandom_range(0, 1));
      v.exp_beats = v.nk * v.no;
      v.exp_addr0 = v.base;
      if (v.exp_beats < 6) v.restart = 0;
      run_pass(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
